ddr_cmd_issuer: RTL and testbench
=================================

# ddr_cmd_issuer

Controller-side DDR4 command and write-data issuer for a single rank. It accepts one read or write request at a time and drives a closed-page sequence onto the DDR command, address and DQ pins of the DIMM: ACT, then RD/WR, then write burst (writes only), then PRE. It sits between the controller scheduler and the `ddr_interface` pins, and is the initiator for the DIMM model's command decoder and data capture.

## Interface
Parameters:
- `T_RCD`, 16: cycles from ACT to RD/WR (≥2).
- `CWL`, 12: cycles from WR to the first write-data cycle (≥2).
- `T_WR`, 16: cycles from the last write-data cycle to PRE.
- `T_RTP`, 8: cycles from RD to PRE.
- `T_RP`, 16: cycles from PRE until `req_ready` may rise.

Ports:
- Clock and reset: one clock, `CK_t`; reset `reset_n` is asynchronous and active-low.
- `CK_t`, in, 1: command clock; all outputs change on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: high only in IDLE.
- `req_wr`, in, 1: 1 = write, 0 = read.
- `req_bc4`, in, 1: 1 = BC4, 0 = BL8.
- `req_bg`, in, 2: bank group.
- `req_ba`, in, 2: bank.
- `req_row`, in, 15: row address.
- `req_col`, in, 10: column address.
- `req_wdata`, in, 64: write data, beat0 in [7:0].
- `cs_n`, `act_n`, `RAS_n_A16`, `CAS_n_A15`, `WE_n_A14`, out, 1 each: command pins.
- `A13`, `A12_BC_n`, `A11`, `A10_AP`, out, 1 each: address pins.
- `A9_A0`, out, 10: address pins.
- `bg_addr`, out, 2; `ba_addr`, out, 2: bank-group and bank pins.
- `dq_rise`, `dq_fall`, out, 8 each: DQ beat for the rising and falling half-cycle (an external serializer does the DDR output).
- `dq_oe`, `dqs_oe`, out, 1 each: DQ and DQS output enables.
- `done`, out, 1: one-cycle pulse in the cycle PRE is driven.

## Operation
- Command encoding {cs_n, act_n, RAS, CAS, WE}:
  - ACT = 5'b00, then row bits.
  - WR = 5'b01100.
  - RD = 5'b01101.
  - PRE = 5'b01010.
  - Idle (DES) = 5'b11111, with all address pins 0.
- ACT pins:
  - {WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0} = `req_row`.
  - RAS_n_A16 = 0 and CAS_n_A15 = 0.
  - bg/ba driven from the request.
- RD/WR pins:
  - A9_A0 = col.
  - A10_AP = 0 (no auto-precharge).
  - A12_BC_n = ~bc4.
  - A13 = A11 = 0.
  - bg/ba repeated.
- PRE pins: A10_AP = 0; bg/ba repeated.
- Accept: `req_valid & req_ready` at a rising edge. The request fields are latched and the block leaves IDLE.
- FSM states: IDLE → ACT → RCD_WAIT → CAS → (wr: WR_LAT → WR_BURST → WR_REC | rd: RD_REC) → PRE → RP_WAIT → IDLE.
- Counter: a single down-counter, wide enough for the largest parameter. It is loaded on each state entry; the FSM advances when the count reaches 0.
- Write burst:
  - BL8 is 4 cycles; BC4 is 2 cycles.
  - Cycle k drives dq_rise = wdata[16k+7:16k] and dq_fall = wdata[16k+15:16k+8].
  - dq_oe is high for exactly the burst cycles.
  - dqs_oe is high from one cycle before the burst (preamble) through the last burst cycle.
- A read drives no DQ. Capture of read data is outside this block.

## Timing
- Let cycle 0 be the accept edge.
- ACT is on the pins at cycle 1.
- RD/WR is at cycle 1+T_RCD.
- Write:
  - dqs_oe rises at cycle 1+T_RCD+CWL−1.
  - Data runs from 1+T_RCD+CWL for 4 cycles (BL8) or 2 cycles (BC4).
  - PRE comes T_WR cycles after the last data cycle.
- Read: PRE at 1+T_RCD+T_RTP.
- `done` pulses with PRE.
- `req_ready` returns T_RP cycles after PRE. The earliest next ACT is the cycle after that accept.
- Every non-command cycle drives DES. Exactly one command cycle occurs per ACT, CAS and PRE.
- `req_valid` while not ready is ignored. The request is held in the latch, so input changes after accept have no effect.
- Reset values: FSM IDLE; command pins 5'b11111; all address pins, `bg_addr`, `ba_addr`, `dq_rise`, `dq_fall`, `dq_oe`, `dqs_oe` and `done` all 0; `req_ready` 1 once reset is released.
- Reset mid-operation aborts immediately to these values. No PRE is issued, and the bank is left to the memory's own reset.

## Structure
- Shared package `ddr_pkg`:
  - command-encoding constants ACT_C, WR_C, RD_C, PRE_C, DES_C;
  - FSM state enum `issuer_state_t`;
  - request struct `issue_req_t` {wr, bc4, bg, ba, row, col, wdata}.
- Optional sub-module `wr_burst_shifter`: loads 64-bit data on CAS and shifts out 16 bits per cycle when enabled.

## Test plan
- Write BL8, bg=1, ba=2, row=0x1A5, col=0x040, wdata=0x0706050403020100, default parameters:
  - ACT at cycle 1; WR at cycle 17 with A12_BC_n=1.
  - dqs_oe at cycle 28; dq_oe at cycles 29–32, with dq_rise/dq_fall = 00/01, 02/03, 04/05, 06/07.
  - PRE and `done` at cycle 49.
  - `req_ready` at cycle 65.
- Read BC4, col=0x3FF: RD at cycle 17 with A12_BC_n=0 and A9_A0=0x3FF; dq_oe never high; PRE at cycle 25.
- Write BC4: exactly 2 dq_oe cycles, carrying bytes 00–03 only.
- `req_valid` held high continuously:
  - second accept occurs only when `req_ready` is high;
  - no command overlap;
  - exactly one ACT, one CAS and one PRE per request.
- Assert `reset_n` low during WR_BURST: all outputs return to reset values asynchronously; the next request restarts with ACT at cycle 1.
- Parameters T_RCD=2, CWL=2, T_WR=1, T_RTP=1, T_RP=1: same ordering holds with no skipped or duplicated command cycles.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR4 issuer definitions: command encodings, FSM states and the latched request.
package ddr_pkg;

  localparam logic [1:0] ACT_C = 2'b00;
  localparam logic [4:0] WR_C  = 5'b01100;
  localparam logic [4:0] RD_C  = 5'b01101;
  localparam logic [4:0] PRE_C = 5'b01010;
  localparam logic [4:0] DES_C = 5'b11111;

  localparam int unsigned BeatW = 16;

  typedef enum logic [3:0] {
    StIdle,
    StAct,
    StRcdWait,
    StCas,
    StWrLat,
    StWrBurst,
    StWrRec,
    StRdRec,
    StPre,
    StRpWait
  } issuer_state_t;

  typedef struct packed {
    logic        wr;
    logic        bc4;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [9:0]  col;
    logic [63:0] wdata;
  } issue_req_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wr_burst_shifter.sv
// Holds one write burst and presents it one 16-bit beat (rise/fall byte pair) per cycle.
module wr_burst_shifter
  import ddr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [63:0]      data,
  output logic [BeatW-1:0] beat
);

  logic [63:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data;
    end else if (shift) begin
      data_q <= {{BeatW{1'b0}}, data_q[63:BeatW]};
    end
  end

  assign beat = data_q[BeatW-1:0];

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Closed-page DDR4 issuer: one request at a time as ACT, RD/WR, write burst, PRE on the DIMM pins.
module ddr_cmd_issuer
  import ddr_pkg::*;
#(
  parameter int unsigned T_RCD = 16,
  parameter int unsigned CWL   = 12,
  parameter int unsigned T_WR  = 16,
  parameter int unsigned T_RTP = 8,
  parameter int unsigned T_RP  = 16
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_bc4,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [14:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [63:0] req_wdata,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [7:0]  dq_rise,
  output logic [7:0]  dq_fall,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        done
);

  localparam int unsigned CntMax = max_of(max_of(max_of(T_RCD, CWL), max_of(T_WR, T_RTP)), T_RP);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Wait states are entered one cycle after the preceding command, hence the -2/-1 loads.
  localparam cnt_t RcdLoad = cnt_t'(T_RCD - 2);
  localparam cnt_t CwlLoad = cnt_t'(CWL - 2);
  localparam cnt_t WrLoad  = cnt_t'(T_WR - 1);
  localparam cnt_t RtpLoad = cnt_t'((T_RTP > 1) ? T_RTP - 2 : 0);
  localparam cnt_t RpLoad  = cnt_t'(T_RP - 1);

  issuer_state_t state_q;
  cnt_t          cnt_q;
  issue_req_t    req_q;
  issue_req_t    req_in;
  logic          ready_q;
  logic [4:0]    cmd_q;
  logic [13:0]   addr_q;
  logic [1:0]    bg_q, ba_q;
  logic [7:0]    dq_rise_q, dq_fall_q;
  logic          dq_oe_q, dqs_oe_q, done_q;
  logic [BeatW-1:0] beat;

  assign req_in = '{wr: req_wr, bc4: req_bc4, bg: req_bg, ba: req_ba,
                    row: req_row, col: req_col, wdata: req_wdata};

  wr_burst_shifter u_shifter (
    .clk   (CK_t),
    .rst_n (reset_n),
    .load  ((state_q == StCas) && req_q.wr),
    .shift (state_q == StWrBurst),
    .data  (req_q.wdata),
    .beat  (beat)
  );

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= '0;
      ready_q   <= 1'b1;
      cmd_q     <= DES_C;
      addr_q    <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      dq_rise_q <= '0;
      dq_fall_q <= '0;
      dq_oe_q   <= 1'b0;
      dqs_oe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Every cycle defaults to DES with quiet pins; command states override below.
      cmd_q     <= DES_C;
      addr_q    <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      dq_rise_q <= '0;
      dq_fall_q <= '0;
      dq_oe_q   <= 1'b0;
      dqs_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid && ready_q) begin
            req_q   <= req_in;
            ready_q <= 1'b0;
            state_q <= StAct;
          end
        end
        StAct: begin
          cmd_q   <= {ACT_C, 2'b00, req_q.row[14]};
          addr_q  <= req_q.row[13:0];
          bg_q    <= req_q.bg;
          ba_q    <= req_q.ba;
          cnt_q   <= RcdLoad;
          state_q <= StRcdWait;
        end
        StRcdWait: begin
          if (cnt_q == '0) state_q <= StCas;
          else             cnt_q   <= cnt_q - cnt_t'(1);
        end
        StCas: begin
          cmd_q  <= req_q.wr ? WR_C : RD_C;
          addr_q <= {1'b0, ~req_q.bc4, 1'b0, 1'b0, req_q.col};
          bg_q   <= req_q.bg;
          ba_q   <= req_q.ba;
          if (req_q.wr) begin
            cnt_q   <= CwlLoad;
            state_q <= StWrLat;
          end else if (T_RTP > 1) begin
            cnt_q   <= RtpLoad;
            state_q <= StRdRec;
          end else begin
            state_q <= StPre;
          end
        end
        StWrLat: begin
          if (cnt_q == '0) begin
            dqs_oe_q <= 1'b1;  // DQS preamble cycle
            cnt_q    <= cnt_t'(req_q.bc4 ? 1 : 3);
            state_q  <= StWrBurst;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        StWrBurst: begin
          dqs_oe_q  <= 1'b1;
          dq_oe_q   <= 1'b1;
          dq_rise_q <= beat[7:0];
          dq_fall_q <= beat[15:8];
          if (cnt_q == '0) begin
            // Write recovery counts from the end of the last data cycle.
            cnt_q   <= WrLoad;
            state_q <= StWrRec;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        StWrRec, StRdRec: begin
          if (cnt_q == '0) state_q <= StPre;
          else             cnt_q   <= cnt_q - cnt_t'(1);
        end
        StPre: begin
          cmd_q   <= PRE_C;
          bg_q    <= req_q.bg;
          ba_q    <= req_q.ba;
          done_q  <= 1'b1;
          cnt_q   <= RpLoad;
          state_q <= StRpWait;
        end
        StRpWait: begin
          if (cnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign cs_n      = cmd_q[4];
  assign act_n     = cmd_q[3];
  assign RAS_n_A16 = cmd_q[2];
  assign CAS_n_A15 = cmd_q[1];
  assign WE_n_A14  = cmd_q[0];
  assign A13       = addr_q[13];
  assign A12_BC_n  = addr_q[12];
  assign A11       = addr_q[11];
  assign A10_AP    = addr_q[10];
  assign A9_A0     = addr_q[9:0];
  assign bg_addr   = bg_q;
  assign ba_addr   = ba_q;
  assign dq_rise   = dq_rise_q;
  assign dq_fall   = dq_fall_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_oe    = dqs_oe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Bench for ddr_cmd_issuer: default and minimum timing instances checked cycle by cycle.
module tb_ddr_cmd_issuer;
  import ddr_pkg::*;

  typedef struct packed {
    logic        ready;
    logic [4:0]  cmd;
    logic [13:0] addr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        dq_oe;
    logic        dqs_oe;
    logic        done;
  } out_t;

  typedef struct packed {
    logic       valid;
    issue_req_t req;
  } drv_t;

  typedef struct {
    int         d;
    issue_req_t req;
    bit         keep;
    int         exp_cas;
    int         exp_pre;
    int         exp_rdy;
    int         exp_beats;
  } vec_t;

  function automatic int rcd_of(input int d); return (d == 0) ? 16 : 2; endfunction
  function automatic int cwl_of(input int d); return (d == 0) ? 12 : 2; endfunction
  function automatic int twr_of(input int d); return (d == 0) ? 16 : 1; endfunction
  function automatic int rtp_of(input int d); return (d == 0) ? 8 : 1;  endfunction
  function automatic int trp_of(input int d); return (d == 0) ? 16 : 1; endfunction

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  drv_t       drv [2];
  out_t       mon [2];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       ready, cs_n, act_n, ras, cas, we, a13, a12, a11, a10;
    logic [9:0] a9_0;
    logic [1:0] bg, ba;
    logic [7:0] rise, fall;
    logic       dq_oe, dqs_oe, done;

    ddr_cmd_issuer #(
      .T_RCD (rcd_of(g)),
      .CWL   (cwl_of(g)),
      .T_WR  (twr_of(g)),
      .T_RTP (rtp_of(g)),
      .T_RP  (trp_of(g))
    ) u_dut (
      .CK_t      (clk),
      .reset_n   (rst_n[g]),
      .req_valid (drv[g].valid),
      .req_ready (ready),
      .req_wr    (drv[g].req.wr),
      .req_bc4   (drv[g].req.bc4),
      .req_bg    (drv[g].req.bg),
      .req_ba    (drv[g].req.ba),
      .req_row   (drv[g].req.row),
      .req_col   (drv[g].req.col),
      .req_wdata (drv[g].req.wdata),
      .cs_n      (cs_n),
      .act_n     (act_n),
      .RAS_n_A16 (ras),
      .CAS_n_A15 (cas),
      .WE_n_A14  (we),
      .A13       (a13),
      .A12_BC_n  (a12),
      .A11       (a11),
      .A10_AP    (a10),
      .A9_A0     (a9_0),
      .bg_addr   (bg),
      .ba_addr   (ba),
      .dq_rise   (rise),
      .dq_fall   (fall),
      .dq_oe     (dq_oe),
      .dqs_oe    (dqs_oe),
      .done      (done)
    );

    assign mon[g] = {ready, cs_n, act_n, ras, cas, we, a13, a12, a11, a10, a9_0, bg, ba,
                     rise, fall, dq_oe, dqs_oe, done};
  end

  task automatic chk(input string name, input int d, input int r, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, r, got, exp);
    end
  endtask

  function automatic int pre_of(input int d, input issue_req_t q);
    int cas_c = 1 + rcd_of(d);
    int beats = q.bc4 ? 2 : 4;
    return q.wr ? cas_c + cwl_of(d) + beats + twr_of(d) : cas_c + rtp_of(d);
  endfunction

  // Expected pins r cycles after the accept edge, straight from the timing rules.
  function automatic out_t model(input int d, input issue_req_t q, input int r);
    out_t o;
    int   cas_c = 1 + rcd_of(d);
    int   beats = q.bc4 ? 2 : 4;
    int   d0    = cas_c + cwl_of(d);
    int   pre   = pre_of(d, q);
    int   k;
    o     = '0;
    o.cmd = 5'b11111;
    if (r == 1) begin
      o.cmd  = {4'b0000, q.row[14]};
      o.addr = q.row[13:0];
      o.bg   = q.bg;
      o.ba   = q.ba;
    end
    if (r == cas_c) begin
      o.cmd  = q.wr ? 5'b01100 : 5'b01101;
      o.addr = {1'b0, ~q.bc4, 2'b00, q.col};
      o.bg   = q.bg;
      o.ba   = q.ba;
    end
    if (r == pre) begin
      o.cmd  = 5'b01010;
      o.bg   = q.bg;
      o.ba   = q.ba;
      o.done = 1'b1;
    end
    if (q.wr && r >= d0 - 1 && r < d0 + beats) o.dqs_oe = 1'b1;
    if (q.wr && r >= d0 && r < d0 + beats) begin
      k        = r - d0;
      o.dq_oe  = 1'b1;
      o.rise   = q.wdata[16*k +: 8];
      o.fall   = q.wdata[16*k+8 +: 8];
    end
    o.ready = (r >= pre + trp_of(d));
    return o;
  endfunction

  function automatic issue_req_t rand_req();
    issue_req_t q;
    q.wr    = 1'($urandom);
    q.bc4   = 1'($urandom);
    q.bg    = 2'($urandom);
    q.ba    = 2'($urandom);
    q.row   = 15'($urandom);
    q.col   = 10'($urandom);
    q.wdata = {$urandom, $urandom};
    return q;
  endfunction

  task automatic run_req(input int d, input issue_req_t rq, input bit keep, input issue_req_t nxt,
                         input bit chk_ms, input int exp_cas, input int exp_pre,
                         input int exp_rdy, input int exp_beats);
    int   n = 0;
    int   last;
    int   obs_cas = -1, obs_pre = -1, obs_rdy = -1;
    int   n_act = 0, n_cas = 0, n_pre = 0, n_beat = 0;
    out_t got;
    while (mon[d].ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      chk("ready_wait", d, n, 64'(mon[d].ready), 64'd1);
      return;
    end
    drv[d].valid = 1'b1;
    drv[d].req   = rq;
    @(posedge clk); #1;
    if (keep) drv[d] = '{valid: 1'b1, req: nxt};
    else      drv[d] = '{valid: 1'b0, req: rand_req()};
    last = pre_of(d, rq) + trp_of(d);
    for (int r = 0; r <= last; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
      end
      got = mon[d];
      chk("pins", d, r, 64'(got), 64'(model(d, rq, r)));
      if (got.cmd[4:3] == 2'b00) n_act++;
      if (got.cmd[4:2] == 3'b011) begin
        n_cas++;
        obs_cas = r;
      end
      if (got.cmd == 5'b01010) begin
        n_pre++;
        obs_pre = r;
      end
      if (got.dq_oe) n_beat++;
      if (got.ready && obs_rdy < 0) obs_rdy = r;
    end
    chk("act_count", d, last, 64'(n_act), 64'd1);
    chk("cas_count", d, last, 64'(n_cas), 64'd1);
    chk("pre_count", d, last, 64'(n_pre), 64'd1);
    if (chk_ms) begin
      chk("cas_cycle", d, obs_cas, 64'(obs_cas), 64'(exp_cas));
      chk("pre_cycle", d, obs_pre, 64'(obs_pre), 64'(exp_pre));
      chk("ready_cycle", d, obs_rdy, 64'(obs_rdy), 64'(exp_rdy));
      chk("beat_count", d, last, 64'(n_beat), 64'(exp_beats));
    end
  endtask

  vec_t       tbl [8];
  issue_req_t rlist [12];
  bit         rkeep [12];
  out_t       rst_exp;
  out_t       masked;

  initial begin
    issue_req_t w8, r4, w4, r8;
    w8 = '{wr: 1'b1, bc4: 1'b0, bg: 2'd1, ba: 2'd2, row: 15'h01A5, col: 10'h040,
           wdata: 64'h0706_0504_0302_0100};
    r4 = '{wr: 1'b0, bc4: 1'b1, bg: 2'd3, ba: 2'd0, row: 15'h7FFF, col: 10'h3FF,
           wdata: 64'hDEAD_BEEF_0BAD_F00D};
    w4 = '{wr: 1'b1, bc4: 1'b1, bg: 2'd2, ba: 2'd3, row: 15'h4321, col: 10'h155,
           wdata: 64'h0706_0504_0302_0100};
    r8 = '{wr: 1'b0, bc4: 1'b0, bg: 2'd0, ba: 2'd1, row: 15'h0000, col: 10'h000,
           wdata: 64'h0};
    tbl[0] = '{d: 0, req: w8, keep: 1'b0, exp_cas: 17, exp_pre: 49, exp_rdy: 65, exp_beats: 4};
    tbl[1] = '{d: 0, req: r4, keep: 1'b1, exp_cas: 17, exp_pre: 25, exp_rdy: 41, exp_beats: 0};
    tbl[2] = '{d: 0, req: w4, keep: 1'b1, exp_cas: 17, exp_pre: 47, exp_rdy: 63, exp_beats: 2};
    tbl[3] = '{d: 0, req: r8, keep: 1'b0, exp_cas: 17, exp_pre: 25, exp_rdy: 41, exp_beats: 0};
    tbl[4] = '{d: 1, req: w8, keep: 1'b1, exp_cas: 3, exp_pre: 10, exp_rdy: 11, exp_beats: 4};
    tbl[5] = '{d: 1, req: r8, keep: 1'b1, exp_cas: 3, exp_pre: 4, exp_rdy: 5, exp_beats: 0};
    tbl[6] = '{d: 1, req: w4, keep: 1'b1, exp_cas: 3, exp_pre: 8, exp_rdy: 9, exp_beats: 2};
    tbl[7] = '{d: 1, req: r4, keep: 1'b0, exp_cas: 3, exp_pre: 4, exp_rdy: 5, exp_beats: 0};

    rst_exp     = '0;
    rst_exp.cmd = 5'b11111;
    drv[0]      = '0;
    drv[1]      = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      masked       = mon[d];
      masked.ready = 1'b0;
      chk("reset_pins", d, 0, 64'(masked), 64'(rst_exp));
    end
    @(negedge clk);
    rst_n = 2'b11;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("ready_after_reset", d, 0, 64'(mon[d].ready), 64'd1);

    // Directed table; keep=1 rows leave req_valid high into the next row.
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].d, tbl[i].req, tbl[i].keep, (i < 7) ? tbl[i+1].req : tbl[i].req, 1'b1,
              tbl[i].exp_cas, tbl[i].exp_pre, tbl[i].exp_rdy, tbl[i].exp_beats);
    end

    // Reset in the middle of a write burst, then restart cleanly.
    run_wait_ready(0);
    drv[0] = '{valid: 1'b1, req: w8};
    @(posedge clk); #1;
    drv[0] = '{valid: 1'b0, req: rand_req()};
    repeat (30) @(posedge clk);
    #1;
    chk("burst_before_reset", 0, 30, 64'(mon[0].dq_oe), 64'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    masked       = mon[0];
    masked.ready = 1'b0;
    chk("async_reset_pins", 0, 30, 64'(masked), 64'(rst_exp));
    @(posedge clk); #1;
    masked       = mon[0];
    masked.ready = 1'b0;
    chk("held_reset_pins", 0, 31, 64'(masked), 64'(rst_exp));
    @(negedge clk);
    rst_n[0] = 1'b1;
    run_req(0, w8, 1'b0, w8, 1'b1, 17, 49, 65, 4);

    // Randomised requests against the model on both timing sets.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 12; i++) begin
        rlist[i] = rand_req();
        rkeep[i] = (i < 11) ? 1'($urandom) : 1'b0;
      end
      for (int i = 0; i < 12; i++) begin
        run_req(d, rlist[i], rkeep[i], (i < 11) ? rlist[i+1] : rlist[i], 1'b0, 0, 0, 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic run_wait_ready(input int d);
    int n = 0;
    while (mon[d].ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", d, n, 64'(mon[d].ready), 64'd1);
  endtask

endmodule
